// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_t;

    localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/i2s_receiver_if.sv
// Serial I2S lines plus the parallel sample outputs of the receiver.
// master = the side driving the serial stream, slave = the receiver.
interface i2s_receiver_if #(
    parameter int DW = 16
);
    import i2s_pkg::*;

    logic                 audio_sclk;
    logic                 audio_lrck;
    logic                 audio_dac;
    logic [DW-1:0]        sample_l;
    logic [DW-1:0]        sample_r;
    logic                 sample_valid;
    logic                 frame_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output audio_sclk, audio_lrck, audio_dac,
        input  sample_l, sample_r, sample_valid, frame_err, err_count
    );

    modport slave (
        input  audio_sclk, audio_lrck, audio_dac,
        output sample_l, sample_r, sample_valid, frame_err, err_count
    );

endinterface

// File: rtl/i2s_rx_sync.sv
// Synchronizes sclk/lrck/data into clk_74b and flags sclk rising edges.
// All three outputs are registered together so they refer to the same sclk rise.
module i2s_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_74b,
    input  logic reset_n,
    input  logic audio_sclk,
    input  logic audio_lrck,
    input  logic audio_dac,
    output logic sclk_rise,
    output logic lrck_s,
    output logic data_s
);

    // Bit 0 = sclk, bit 1 = lrck, bit 2 = data; stage 0 is the first flop.
    logic [SYNC_STAGES-1:0][2:0] chain_reg;
    logic                        sclk_prev_reg;
    logic [2:0]                  synced;

    assign synced = chain_reg[SYNC_STAGES-1];

    always_ff @(posedge clk_74b or negedge reset_n) begin
        if (!reset_n) begin
            chain_reg     <= '0;
            sclk_prev_reg <= 1'b0;
            sclk_rise     <= 1'b0;
            lrck_s        <= 1'b0;
            data_s        <= 1'b0;
        end else begin
            chain_reg     <= {chain_reg[SYNC_STAGES-2:0], {audio_dac, audio_lrck, audio_sclk}};
            sclk_prev_reg <= synced[0];
            sclk_rise     <= synced[0] & ~sclk_prev_reg;
            lrck_s        <= synced[1];
            data_s        <= synced[2];
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: deserializes left/right slots into a parallel stereo pair.
// Optional saturating frame-error counter enabled by I2S_RX_ERR_CNT_EN.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int DW          = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk_74b,
    input  logic           reset_n,
    i2s_receiver_if.slave  bus
);

    localparam int                CNT_W  = $clog2(DW + 1);
    localparam logic [CNT_W-1:0]  DW_CNT = CNT_W'(DW);

    logic sclk_rise;
    logic lrck_s;
    logic data_s;
    logic lr_edge;

    rx_state_t       state_reg, state_next;
    chan_t           chan_reg, chan_next;
    logic [CNT_W-1:0] bitcnt_reg, bitcnt_next;
    logic [DW-1:0]   shreg_reg, shreg_next;
    logic [DW-1:0]   left_stage_reg, left_stage_next;
    logic            left_ok_reg, left_ok_next;
    logic            lr_prev_reg, lr_prev_next;
    logic [DW-1:0]   sample_l_reg, sample_l_next;
    logic [DW-1:0]   sample_r_reg, sample_r_next;
    logic            valid_reg, valid_next;
    logic            err_reg, err_next;
    logic [DW-1:0]   shift_word;

    i2s_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_74b    (clk_74b),
        .reset_n    (reset_n),
        .audio_sclk (bus.audio_sclk),
        .audio_lrck (bus.audio_lrck),
        .audio_dac  (bus.audio_dac),
        .sclk_rise  (sclk_rise),
        .lrck_s     (lrck_s),
        .data_s     (data_s)
    );

    assign lr_edge = lrck_s ^ lr_prev_reg;

    // MSB-first: bit count k lands in position DW-1-k.
    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_shift
            assign shift_word[gi] = (bitcnt_reg == CNT_W'(DW - 1 - gi)) ? data_s : shreg_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_74b or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= HUNT;
            chan_reg       <= CH_LEFT;
            bitcnt_reg     <= '0;
            shreg_reg      <= '0;
            left_stage_reg <= '0;
            left_ok_reg    <= 1'b0;
            lr_prev_reg    <= 1'b0;
            sample_l_reg   <= '0;
            sample_r_reg   <= '0;
            valid_reg      <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            chan_reg       <= chan_next;
            bitcnt_reg     <= bitcnt_next;
            shreg_reg      <= shreg_next;
            left_stage_reg <= left_stage_next;
            left_ok_reg    <= left_ok_next;
            lr_prev_reg    <= lr_prev_next;
            sample_l_reg   <= sample_l_next;
            sample_r_reg   <= sample_r_next;
            valid_reg      <= valid_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        chan_next       = chan_reg;
        bitcnt_next     = bitcnt_reg;
        shreg_next      = shreg_reg;
        left_stage_next = left_stage_reg;
        left_ok_next    = left_ok_reg;
        lr_prev_next    = lr_prev_reg;
        sample_l_next   = sample_l_reg;
        sample_r_next   = sample_r_reg;
        valid_next      = 1'b0;
        err_next        = 1'b0;

        if (sclk_rise) begin
            lr_prev_next = lrck_s;
            case (state_reg)
                HUNT: begin
                    // The bit on the lrck-edge rise belongs to the previous slot.
                    if (lr_edge) begin
                        state_next  = SHIFT;
                        chan_next   = chan_t'(lrck_s);
                        bitcnt_next = '0;
                    end
                end
                SHIFT: begin
                    if (lr_edge) begin
                        if (bitcnt_reg == DW_CNT) begin
                            if (chan_reg == CH_LEFT) begin
                                left_stage_next = shreg_reg;
                                left_ok_next    = 1'b1;
                            end else if (left_ok_reg) begin
                                sample_l_next = left_stage_reg;
                                sample_r_next = shreg_reg;
                                valid_next    = 1'b1;
                                left_ok_next  = 1'b0;
                            end
                        end else begin
                            err_next     = 1'b1;
                            left_ok_next = 1'b0;
                        end
                        chan_next   = chan_t'(lrck_s);
                        bitcnt_next = '0;
                    end else if (bitcnt_reg < DW_CNT) begin
                        shreg_next  = shift_word;
                        bitcnt_next = bitcnt_reg + CNT_W'(1);
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    assign bus.sample_l     = sample_l_reg;
    assign bus.sample_r     = sample_r_reg;
    assign bus.sample_valid = valid_reg;
    assign bus.frame_err    = err_reg;

`ifdef I2S_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    always_ff @(posedge clk_74b or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt_reg <= '0;
        end else if (err_next && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
        end
    end

    assign bus.err_count = err_cnt_reg;
`else
    assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Drives one random I2S stream into DW=16 and DW=24 receivers at once and
// scoreboards each against a slot-level reference model.
`timescale 1ns/1ps
module tb_i2s_receiver;
    import i2s_pkg::*;

    localparam real SCLK_HALF = 162.76;

    typedef struct {
        bit          is_err;
        logic [31:0] l;
        logic [31:0] r;
    } ev_t;

    logic clk_74b = 1'b0;
    logic reset_n = 1'b0;
    logic sclk = 1'b0;
    logic lrck = 1'b0;
    logic dac  = 1'b0;

    always #6.734 clk_74b = ~clk_74b;

    i2s_receiver_if #(.DW(16)) if16 ();
    i2s_receiver_if #(.DW(24)) if24 ();

    assign if16.audio_sclk = sclk;
    assign if16.audio_lrck = lrck;
    assign if16.audio_dac  = dac;
    assign if24.audio_sclk = sclk;
    assign if24.audio_lrck = lrck;
    assign if24.audio_dac  = dac;

    i2s_receiver #(.DW(16), .SYNC_STAGES(2)) dut16 (
        .clk_74b (clk_74b),
        .reset_n (reset_n),
        .bus     (if16.slave)
    );

    i2s_receiver #(.DW(24), .SYNC_STAGES(2)) dut24 (
        .clk_74b (clk_74b),
        .reset_n (reset_n),
        .bus     (if24.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    ev_t q0[$];
    ev_t q1[$];

    // Reference model state, one stream shared by both widths.
    int          dwv[2] = '{16, 24};
    bit          hunt;
    bit          lr_prev_m;
    bit          cur_ch;
    int          cur_bits;
    logic [31:0] cur_word;
    bit          left_ok[2];
    logic [31:0] left_val[2];
    logic [31:0] exp_l[2];
    logic [31:0] exp_r[2];
    int          errcnt[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int d, input ev_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic get_out(input int d, output logic [31:0] l, output logic [31:0] r,
                           output logic v, output logic e, output logic [15:0] ec);
        if (d == 0) begin
            l = 32'(if16.sample_l); r = 32'(if16.sample_r);
            v = if16.sample_valid;  e = if16.frame_err; ec = if16.err_count;
        end else begin
            l = 32'(if24.sample_l); r = 32'(if24.sample_r);
            v = if24.sample_valid;  e = if24.frame_err; ec = if24.err_count;
        end
    endtask

    function automatic logic [15:0] exp_ec(input int d);
`ifdef I2S_RX_ERR_CNT_EN
        return 16'(errcnt[d]);
`else
        return 16'(d - d);
`endif
    endfunction

    task automatic model_reset();
        hunt      = 1'b1;
        lr_prev_m = 1'b0;
        cur_bits  = 0;
        for (int d = 0; d < 2; d++) begin
            left_ok[d] = 1'b0;
            exp_l[d]   = '0;
            exp_r[d]   = '0;
            errcnt[d]  = 0;
        end
    endtask

    // A slot of n sclk periods carries n-1 usable bits after the one-bit delay.
    task automatic end_slot();
        for (int d = 0; d < 2; d++) begin
            logic [31:0] v;
            ev_t e;
            v = cur_word >> (32 - dwv[d]);
            if (cur_bits < dwv[d]) begin
                e.is_err = 1'b1; e.l = '0; e.r = '0;
                push_ev(d, e);
                left_ok[d] = 1'b0;
                if (errcnt[d] < 65535) errcnt[d]++;
            end else if (cur_ch == 1'b0) begin
                left_val[d] = v;
                left_ok[d]  = 1'b1;
            end else if (left_ok[d]) begin
                e.is_err = 1'b0; e.l = left_val[d]; e.r = v;
                push_ev(d, e);
                exp_l[d]   = left_val[d];
                exp_r[d]   = v;
                left_ok[d] = 1'b0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            logic [31:0] l, r;
            logic v, e;
            logic [15:0] ec;
            get_out(d, l, r, v, e, ec);
            check($sformatf("%s dw%0d sample_l", tag, dwv[d]), l, exp_l[d]);
            check($sformatf("%s dw%0d sample_r", tag, dwv[d]), r, exp_r[d]);
            check($sformatf("%s dw%0d err_count", tag, dwv[d]), 32'(ec), 32'(exp_ec(d)));
            check($sformatf("%s dw%0d pending_events", tag, dwv[d]),
                  (d == 0) ? q0.size() : q1.size(), 0);
        end
    endtask

    task automatic do_reset();
        check_outputs("pre_reset");
        @(posedge clk_74b);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            logic [31:0] l, r;
            logic v, e;
            logic [15:0] ec;
            get_out(d, l, r, v, e, ec);
            check($sformatf("reset dw%0d sample_l", dwv[d]), l, 0);
            check($sformatf("reset dw%0d sample_r", dwv[d]), r, 0);
            check($sformatf("reset dw%0d sample_valid", dwv[d]), 32'(v), 0);
            check($sformatf("reset dw%0d frame_err", dwv[d]), 32'(e), 0);
            check($sformatf("reset dw%0d err_count", dwv[d]), 32'(ec), 0);
        end
        repeat (3) @(posedge clk_74b);
        #2 reset_n = 1'b1;
    endtask

    task automatic send_slot(input bit ch, input int n, input logic [31:0] word, input int rst_at = -1);
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) do_reset();
            if (i == 0) begin
                if (ch != lr_prev_m) begin
                    if (!hunt) end_slot();
                    hunt     = 1'b0;
                    cur_ch   = ch;
                    cur_bits = n - 1;
                    cur_word = word;
                end else if (!hunt) begin
                    cur_bits += n;
                end
                lr_prev_m = ch;
            end
            lrck = ch;
            dac  = (i >= 1 && i <= 32) ? word[32-i] : 1'b0;
            #(SCLK_HALF) sclk = 1'b1;
            #(SCLK_HALF) sclk = 1'b0;
        end
        $display("slot ch=%0d periods=%0d word=%h", ch, n, word);
    endtask

    // Monitor: every valid/err pulse must match the head of that receiver's queue.
    always @(negedge clk_74b) begin
        if (reset_n) begin
            for (int d = 0; d < 2; d++) begin
                logic [31:0] l, r;
                logic v, e;
                logic [15:0] ec;
                int qs;
                ev_t x;
                get_out(d, l, r, v, e, ec);
                if (v || e) begin
                    qs = (d == 0) ? q0.size() : q1.size();
                    check($sformatf("dw%0d valid_and_err_exclusive", dwv[d]), 32'(v & e), 0);
                    check($sformatf("dw%0d event_expected", dwv[d]), 32'(qs != 0), 1);
                    if (qs != 0) begin
                        x = (d == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("dw%0d event_kind_err", dwv[d]), 32'(e), 32'(x.is_err));
                        if (!x.is_err) begin
                            check($sformatf("dw%0d pair sample_l", dwv[d]), l, x.l);
                            check($sformatf("dw%0d pair sample_r", dwv[d]), r, x.r);
                        end
                        $display("dw%0d event err=%0d l=%h r=%h", dwv[d], e, l, r);
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk_74b);
        #1 check_outputs("reset_state");
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk_74b);

        // Stream begins mid-right-slot, then fixed-value frames.
        send_slot(1'b1, 20, $urandom);
        for (int k = 0; k < 4; k++) begin
            send_slot(1'b0, 32, {16'hA5C3, 16'($urandom)});
            send_slot(1'b1, 32, {16'h1234, 16'($urandom)});
        end
        check_outputs("fixed_frames");

        // Short left slot, then random good frames and boundary values.
        send_slot(1'b0, 10, $urandom);
        send_slot(1'b1, 32, $urandom);
        for (int k = 0; k < 3; k++) begin
            send_slot(1'b0, 32, $urandom);
            send_slot(1'b1, 32, $urandom);
        end
        for (int k = 0; k < 2; k++) begin
            send_slot(1'b0, 32, {24'h800001, 8'($urandom)});
            send_slot(1'b1, 32, {24'h7FFFFE, 8'($urandom)});
        end
        repeat (200) @(posedge clk_74b);
        #1 check_outputs("sclk_stopped");

        // Reset in the middle of a left slot, then a full frame to recover.
        send_slot(1'b0, 32, $urandom, 12);
        send_slot(1'b1, 32, $urandom);
        send_slot(1'b0, 32, $urandom);
        send_slot(1'b1, 32, $urandom);

        // Five short slots.
        send_slot(1'b0, 8, $urandom);
        send_slot(1'b1, 12, $urandom);
        send_slot(1'b0, 5, $urandom);
        send_slot(1'b1, 15, $urandom);
        send_slot(1'b0, 2, $urandom);
        send_slot(1'b1, 32, $urandom);
        send_slot(1'b0, 32, $urandom);
        send_slot(1'b1, 32, $urandom);
        send_slot(1'b0, 32, $urandom);
        repeat (50) @(posedge clk_74b);
        #1 check_outputs("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
